// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - states, opcodes, select encodings and control word for the multicycle controller
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BEQ, S_JALR, S_JAL, S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_READ   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // wait_ready marks states whose strobes and exit wait on the memory handshake
  typedef struct packed {
    logic       mem_req;
    logic       adrsrc;
    logic       irwrite;
    logic       memwrite;
    logic       pcupdate;
    logic       branch;
    logic       regwrite;
    logic       done;
    logic       wait_ready;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [1:0] aluop;
  } ctrl_word_t;

  function automatic logic [1:0] imm_fmt(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_output_decoder.sv
// rtl/ctrl_output_decoder.sv - combinational state to control word decode
module ctrl_output_decoder
  import ctrl_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_req    = 1'b1;
        cw.irwrite    = 1'b1;
        cw.pcupdate   = 1'b1;
        cw.wait_ready = 1'b1;
        cw.alusrca    = SRCA_PC;
        cw.alusrcb    = SRCB_FOUR;
        cw.resultsrc  = RES_ALU;
        cw.aluop      = ALUOP_ADD;
      end
      S_DECODE: begin
        cw.alusrca = SRCA_OLDPC;
        cw.alusrcb = SRCB_IMM;
        cw.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_JALR: begin
        cw.alusrca = SRCA_RS1;
        cw.alusrcb = SRCB_IMM;
        cw.aluop   = ALUOP_ADD;
      end
      S_MEMREAD: begin
        cw.mem_req    = 1'b1;
        cw.adrsrc     = 1'b1;
        cw.wait_ready = 1'b1;
      end
      S_MEMWB: begin
        cw.resultsrc = RES_READ;
        cw.regwrite  = 1'b1;
        cw.done      = 1'b1;
      end
      S_MEMWRITE: begin
        cw.mem_req    = 1'b1;
        cw.adrsrc     = 1'b1;
        cw.memwrite   = 1'b1;
        cw.done       = 1'b1;
        cw.wait_ready = 1'b1;
      end
      S_EXECR: begin
        cw.alusrca = SRCA_RS1;
        cw.alusrcb = SRCB_RS2;
        cw.aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        cw.alusrca = SRCA_RS1;
        cw.alusrcb = SRCB_IMM;
        cw.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        cw.resultsrc = RES_ALUOUT;
        cw.regwrite  = 1'b1;
        cw.done      = 1'b1;
      end
      S_BEQ: begin
        cw.branch    = 1'b1;
        cw.done      = 1'b1;
        cw.alusrca   = SRCA_RS1;
        cw.alusrcb   = SRCB_RS2;
        cw.aluop     = ALUOP_SUB;
        cw.resultsrc = RES_ALUOUT;
      end
      S_JAL: begin
        cw.pcupdate  = 1'b1;
        cw.alusrca   = SRCA_OLDPC;
        cw.alusrcb   = SRCB_FOUR;
        cw.aluop     = ALUOP_ADD;
        cw.resultsrc = RES_ALUOUT;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I control FSM with memory handshake and illegal trap
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       memwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic [1:0] immsrc,
  output logic [1:0] aluop,
  output logic       instr_done,
  output logic       illegal
);

  state_t     state;
  state_t     state_next;
  ctrl_word_t cw;
  logic       step_ok;
  logic       illegal_q;

  ctrl_output_decoder u_decoder (
    .state (state),
    .cw    (cw)
  );

  // handshake states only complete when memory answers; others always step
  assign step_ok = ~cw.wait_ready | mem_ready;

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECR;
          OP_ITYPE:     state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          OP_JALR:      state_next = S_JALR;
          default:      state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_JALR:     state_next = S_JAL;
      S_JAL:      state_next = S_ALUWB;
      S_ILLEGAL:  state_next = S_ILLEGAL;
      default:    state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RESET_STATE;
      illegal_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == S_ILLEGAL) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    mem_req    = cw.mem_req;
    adrsrc     = cw.adrsrc;
    irwrite    = cw.irwrite & step_ok;
    memwrite   = cw.memwrite;
    pcwrite    = (cw.pcupdate & step_ok) | (cw.branch & zero);
    regwrite   = cw.regwrite;
    alusrca    = cw.alusrca;
    alusrcb    = cw.alusrcb;
    resultsrc  = cw.resultsrc;
    immsrc     = imm_fmt(op);
    aluop      = cw.aluop;
    instr_done = cw.done & step_ok;
    // reset silences every strobe and select, even mid-access
    if (rst) begin
      mem_req    = 1'b0;
      adrsrc     = 1'b0;
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      pcwrite    = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 2'b00;
      alusrcb    = 2'b00;
      resultsrc  = 2'b00;
      immsrc     = 2'b00;
      aluop      = 2'b00;
      instr_done = 1'b0;
    end
  end

  assign illegal = illegal_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control FSM that sequences a shared-memory, shared-ALU multicycle RV32I datapath.
- Replaces the single-cycle main decoder and feeds the existing ALU decoder through `aluop`.
- Supports lw, sw, R-type, I-type arithmetic, beq, jal and jalr.
- Handles a variable-latency memory through a req/ready handshake and flags illegal opcodes.

Parameters:
- `RESET_STATE`, `S_FETCH`: state entered on reset.

Ports:
- `clk`  input  1  system clock, rising edge
- `rst`  input  1  synchronous, active-high reset
- `op`  input  7  opcode field from the instruction register
- `zero`  input  1  ALU zero flag
- `mem_ready`  input  1  memory completes the current access this cycle
- `mem_req`  output  1  memory access request; held until `mem_ready`
- `adrsrc`  output  1  memory address select: 0 = PC, 1 = ALUOut
- `irwrite`  output  1  instruction register / oldPC load enable
- `memwrite`  output  1  store strobe
- `pcwrite`  output  1  PC load enable (pcupdate OR (branch AND zero))
- `regwrite`  output  1  register file write enable
- `alusrca`  output  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1
- `alusrcb`  output  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4
- `resultsrc`  output  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result
- `immsrc`  output  2  immediate format: I = 00, S = 01, B = 10, J = 11
- `aluop`  output  2  to ALU decoder: 00 = add, 01 = sub/compare, 10 = funct-decoded
- `instr_done`  output  1  one-cycle pulse when an instruction retires
- `illegal`  output  1  sticky; set on an unsupported opcode

Behaviour:
Reset
- Synchronous, active-high.
- On a clock edge with `rst` = 1: state becomes FETCH and `illegal` clears to 0.
- While `rst` = 1, these outputs are forced to 0: `mem_req`, `irwrite`, `memwrite`, `pcwrite`, `regwrite`, `instr_done`.
- All selects are 0 during reset.
- Reset mid-access (for example in MEMREAD): the request is dropped and no strobe fires. The next fetch starts 1 cycle after `rst` falls.

Output timing
- Outputs depend only on state, except that strobes gated by `mem_ready` or `zero` are combinational.
- Unlisted outputs in a state are 0.

States and transitions
- FETCH: `mem_req`=1, `adrsrc`=0, `alusrca`=00, `alusrcb`=10, `aluop`=00, `resultsrc`=10.
  - `irwrite` and `pcwrite` assert only in the cycle `mem_ready`=1; that cycle goes to DECODE.
  - Otherwise stay in FETCH.
- DECODE: `alusrca`=01, `alusrcb`=01, `aluop`=00 (branch/jal target into ALUOut). Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - 1100111 → JALR
  - any other opcode → ILLEGAL
- MEMADR: `alusrca`=10, `alusrcb`=01, `aluop`=00.
  - `op`=0000011 → MEMREAD; otherwise → MEMWRITE.
- MEMREAD: `mem_req`=1, `adrsrc`=1. On `mem_ready` → MEMWB.
- MEMWB: `resultsrc`=01, `regwrite`=1, `instr_done`=1 → FETCH.
- MEMWRITE: `mem_req`=1, `adrsrc`=1, `memwrite`=1.
  - `memwrite` is held with `mem_req` until `mem_ready`.
  - On `mem_ready`: `instr_done`=1 → FETCH.
- EXECR: `alusrca`=10, `alusrcb`=00, `aluop`=10 → ALUWB.
- EXECI: `alusrca`=10, `alusrcb`=01, `aluop`=10 → ALUWB.
- ALUWB: `resultsrc`=00, `regwrite`=1, `instr_done`=1 → FETCH.
- BEQ: `alusrca`=10, `alusrcb`=00, `aluop`=01, `resultsrc`=00.
  - `pcwrite` = `zero`.
  - `instr_done`=1 → FETCH.
- JALR: `alusrca`=10, `alusrcb`=01, `aluop`=00 (rs1+imm into ALUOut) → JAL.
- JAL: `alusrca`=01, `alusrcb`=10, `aluop`=00, `resultsrc`=00, `pcwrite`=1 → ALUWB (writes oldPC+4 to rd).
- ILLEGAL: `illegal`=1 and all strobes 0. Remain in ILLEGAL until reset.

Immediate format
- `immsrc` is decoded combinationally from `op` in every state:
  - sw → 01
  - beq → 10
  - jal → 11
  - all others → 00

Instruction latency (cycles, with zero-wait memory)
- R/I-type: 4
- lw: 5
- sw: 4
- beq: 3
- jal: 4
- jalr: 5
- Each wait cycle with `mem_ready`=0 adds 1 to the FETCH, MEMREAD or MEMWRITE step it occurs in.

Boundary conditions
- `mem_ready` outside FETCH/MEMREAD/MEMWRITE is ignored.
- `mem_req` never drops before `mem_ready` is seen, except under reset.

Decomposition:
- Package `ctrl_pkg` holds:
  - `state_t` enum
  - opcode constants (`OP_LW`, `OP_SW`, `OP_RTYPE`, `OP_ITYPE`, `OP_BEQ`, `OP_JAL`, `OP_JALR`)
  - select encodings for `alusrca`, `alusrcb`, `resultsrc`, `immsrc`, `aluop`
- Sub-module `ctrl_output_decoder`: combinational, state to control word.
- The top level holds the state register, next-state logic, handshake gating and the sticky `illegal` bit.

Test Plan:
- add, zero-wait memory: `op`=0110011 → states FETCH, DECODE, EXECR, ALUWB. In ALUWB: `regwrite`=1 and `instr_done`=1; `aluop`=10 in EXECR.
- lw, `mem_ready` low for 2 cycles in MEMREAD: `mem_req` stays 1 for 3 cycles and `adrsrc`=1. MEMWB has `resultsrc`=01 and `regwrite`=1. Total 7 cycles.
- sw: `memwrite`=1 only in MEMWRITE and held until `mem_ready`. `regwrite` is never 1. `immsrc`=01.
- beq: with `zero`=1, `pcwrite`=1 in BEQ. With `zero`=0, `pcwrite`=0. Both cases return to FETCH after 3 cycles.
- jalr: path DECODE → JALR → JAL → ALUWB. JALR has `alusrca`=10; JAL has `pcwrite`=1 and `alusrcb`=10.
- Illegal and reset:
  - `op`=1111111 → ILLEGAL; `illegal` stays 1 for 10 cycles and no strobes fire.
  - Reset asserted there, or during MEMREAD → FETCH, with `illegal`=0 and no memory strobe.
